mips_prog_loader: RTL and testbench

Synthesizable program loader for the single-clock MIPS32 core. It receives a framed byte stream, assembles big-endian 32-bit instruction words, and writes them into the core's memory from word address 0 upward. While loading, it holds the core in its halted state; after a good checksum it releases the core with a start pulse. It replaces simulation-time hierarchical preloading of memory and is the write-side counterpart to the core's instruction fetch.

---
 rtl/mips_prog_loader.sv | 96 +++++++++
 tb/tb_mips_prog_loader.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mips_prog_loader.sv
// mips_prog_loader: receives a framed byte stream, writes big-endian words into core memory
// from address 0, holds the core while loading and starts it after a good checksum.
module mips_prog_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              cpu_start,
  input  logic              halted_in,
  output logic              load_done,
  output logic              load_err
);
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, RUN, ERR} state_t;
  localparam logic [16:0] MAX_N = 17'd1 << ADDR_W;
  state_t state, state_n;
  logic fire, hdr, last_byte;
  logic [7:0] n_hi, acc;
  logic [15:0] n, idx, len;
  logic [1:0] bcnt;
  logic [23:0] sr;
  assign rx_ready = state != DONE && state != RUN;
  assign cpu_start = state == DONE;
  assign fire = rx_valid && rx_ready;
  assign hdr = fire && (state == IDLE || state == ERR) && rx_data == 8'hA5;
  assign len = {n_hi, rx_data};
  assign last_byte = fire && state == DATA && bcnt == 2'd3;
  always_comb begin
    state_n = state;
    case (state)
      IDLE, ERR: state_n = hdr ? LEN_HI : state;
      LEN_HI:    state_n = fire ? LEN_LO : state;
      LEN_LO:    state_n = !fire ? state : {1'b0, len} > MAX_N ? ERR : len == 16'd0 ? CSUM : DATA;
      DATA:      state_n = last_byte && idx == n - 16'd1 ? CSUM : state;
      CSUM:      state_n = !fire ? state : rx_data == acc ? DONE : ERR;
      DONE:      state_n = RUN;
      RUN:       state_n = halted_in ? IDLE : state;
      default:   state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_hold <= 1'b1;
      load_done <= 1'b0;
      load_err <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      n_hi <= '0;
      acc <= '0;
      n <= '0;
      idx <= '0;
      bcnt <= '0;
      sr <= '0;
    end else begin
      mem_we <= last_byte;
      if (hdr) begin
        acc <= '0;
        load_done <= 1'b0;
        load_err <= 1'b0;
      end else if (fire && (state == LEN_HI || state == LEN_LO || state == DATA))
        acc <= acc ^ rx_data;
      if (fire && state == LEN_HI) n_hi <= rx_data;
      if (fire && state == LEN_LO) begin
        n <= len;
        idx <= '0;
        bcnt <= '0;
      end
      // bcnt wraps 3->0 on its own, so word boundaries need no bubble
      if (fire && state == DATA) begin
        sr <= {sr[15:0], rx_data};
        bcnt <= bcnt + 2'd1;
        if (bcnt == 2'd3) begin
          mem_addr <= idx[ADDR_W-1:0];
          mem_wdata <= {sr, rx_data};
          idx <= idx + 16'd1;
        end
      end
      if (state_n == ERR && state != ERR) load_err <= 1'b1;
      if (state_n == DONE) begin
        cpu_hold <= 1'b0;
        load_done <= 1'b1;
      end
      if (state == RUN && halted_in) cpu_hold <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mips_prog_loader.sv
// tb_mips_prog_loader: random framed loads against a frame-level reference model,
// using a default-size loader and a 4-word loader for the length boundary.
module tb_mips_prog_loader;
  logic clk = 1'b0, rst;
  logic a_valid, b_valid, a_halt, b_halt;
  logic [7:0] a_data, b_data;
  logic a_ready, a_we, a_hold, a_start, a_done, a_err;
  logic b_ready, b_we, b_hold, b_start, b_done, b_err;
  logic [9:0] a_addr;
  logic [1:0] b_addr;
  logic [31:0] a_wdata, b_wdata;
  always #5 clk = ~clk;

  mips_prog_loader dut_a (
    .clk(clk), .rst(rst), .rx_valid(a_valid), .rx_data(a_data), .rx_ready(a_ready),
    .mem_we(a_we), .mem_addr(a_addr), .mem_wdata(a_wdata), .cpu_hold(a_hold),
    .cpu_start(a_start), .halted_in(a_halt), .load_done(a_done), .load_err(a_err));

  mips_prog_loader #(.ADDR_W(2)) dut_b (
    .clk(clk), .rst(rst), .rx_valid(b_valid), .rx_data(b_data), .rx_ready(b_ready),
    .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata), .cpu_hold(b_hold),
    .cpu_start(b_start), .halted_in(b_halt), .load_done(b_done), .load_err(b_err));

  bit sel;
  logic m_ready, m_we, m_hold, m_start, m_done, m_err;
  logic [15:0] m_addr;
  logic [31:0] m_wdata;
  always_comb begin
    m_ready = sel ? b_ready : a_ready;
    m_we = sel ? b_we : a_we;
    m_hold = sel ? b_hold : a_hold;
    m_start = sel ? b_start : a_start;
    m_done = sel ? b_done : a_done;
    m_err = sel ? b_err : a_err;
    m_addr = sel ? {14'd0, b_addr} : {6'd0, a_addr};
    m_wdata = sel ? b_wdata : a_wdata;
  end

  int checks = 0, errors = 0, starts = 0;
  logic [15:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [31:0] words[$];

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_we) begin
      wr_addr.push_back(m_addr);
      wr_data.push_back(m_wdata);
    end
    if (m_start) starts++;
  end

  task automatic set_in(bit v, logic [7:0] d);
    if (sel) begin b_valid = v; b_data = d; end
    else begin a_valid = v; a_data = d; end
  endtask

  task automatic push(logic [7:0] d);
    int k = 0;
    @(negedge clk);
    set_in(1'b1, d);
    while (!m_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k == 200) check("rx_ready_wait", m_ready, 1);
    @(posedge clk);
    #1 set_in(1'b0, 8'h00);
    if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
  endtask

  task automatic release_core();
    @(negedge clk);
    if (sel) b_halt = 1'b1; else a_halt = 1'b1;
    @(negedge clk);
    a_halt = 1'b0;
    b_halt = 1'b0;
  endtask

  // model: frames longer than the memory are rejected before any data; otherwise all N words
  // land at addresses 0..N-1 and only a matching checksum starts the core
  task automatic run_frame(int n, bit bad, int junk, bit keep, bit stay);
    int maxn;
    logic [7:0] cs, b;
    bit ok;
    maxn = sel ? 4 : 1024;
    if (!keep) begin
      words.delete();
      for (int i = 0; i < n; i++) words.push_back($urandom);
    end
    repeat (junk) begin
      b = 8'($urandom_range(0, 255));
      push(b == 8'hA5 ? 8'h00 : b);
    end
    wr_addr.delete();
    wr_data.delete();
    starts = 0;
    push(8'hA5);
    push(n[15:8]);
    push(n[7:0]);
    ok = n <= maxn && !bad;
    if (n <= maxn) begin
      cs = n[15:8] ^ n[7:0];
      for (int i = 0; i < n; i++)
        for (int j = 3; j >= 0; j--) begin
          push(words[i][8*j+:8]);
          cs ^= words[i][8*j+:8];
        end
      push(cs ^ {7'd0, bad});
    end
    repeat (3) @(negedge clk);
    check("wr_count", wr_addr.size(), n <= maxn ? n : 0);
    for (int i = 0; i < wr_addr.size() && i < n; i++) begin
      check("wr_addr", wr_addr[i], i);
      check("wr_data", wr_data[i], words[i]);
    end
    check("cpu_start_pulses", starts, ok);
    check("load_done", m_done, ok);
    check("load_err", m_err, !ok);
    check("cpu_hold", m_hold, !ok);
    if (ok && !stay) release_core();
  endtask

  initial begin
    a_valid = 0; b_valid = 0; a_data = 0; b_data = 0; a_halt = 0; b_halt = 0;
    sel = 0;
    rst = 1;
    repeat (2) @(negedge clk);
    check("rst_hold", a_hold, 1);
    check("rst_ready", a_ready, 1);
    check("rst_we", a_we, 0);
    check("rst_addr", a_addr, 0);
    check("rst_wdata", a_wdata, 0);
    check("rst_start", a_start, 0);
    check("rst_done", a_done, 0);
    check("rst_err", a_err, 0);
    rst = 0;
    @(negedge clk);
    words = '{32'h20010005, 32'h00411822, 32'hFC000000};
    run_frame(3, 0, 0, 1, 1);
    check("run_ready", a_ready, 0);
    @(negedge clk);
    a_halt = 1'b1;
    @(negedge clk);
    a_halt = 1'b0;
    check("halt_hold", a_hold, 1);
    check("halt_ready", a_ready, 1);
    check("halt_done_kept", a_done, 1);
    run_frame(3, 1, 0, 1, 0);
    run_frame(3, 0, 0, 0, 0);
    push(8'h00); push(8'hFF); push(8'h5A);
    run_frame(0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++)
      run_frame($urandom_range(0, 6), $urandom_range(0, 3) == 0, $urandom_range(0, 3), 0, 0);
    run_frame(1024, 0, 0, 0, 0);
    run_frame(1025, 0, 0, 0, 0);
    sel = 1;
    run_frame(5, 0, 0, 0, 0);
    run_frame(4, 0, 0, 0, 0);
    run_frame(4, 1, 1, 0, 0);
    run_frame(3, 0, 0, 0, 0);
    sel = 0;
    words.delete();
    words.push_back($urandom);
    words.push_back($urandom);
    wr_addr.delete();
    wr_data.delete();
    push(8'hA5); push(8'h00); push(8'h02);
    for (int j = 3; j >= 0; j--) push(words[0][8*j+:8]);
    push(words[1][31:24]);
    push(words[1][23:16]);
    @(negedge clk);
    #2 rst = 1;
    #1;
    check("arst_hold", a_hold, 1);
    check("arst_wdata", a_wdata, 0);
    check("arst_addr", a_addr, 0);
    check("arst_ready", a_ready, 1);
    check("arst_done", a_done, 0);
    @(negedge clk);
    rst = 0;
    repeat (2) @(negedge clk);
    check("arst_wr_count", wr_addr.size(), 1);
    if (wr_data.size() > 0) check("arst_word0", wr_data[0], words[0]);
    run_frame(2, 0, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
